// File: rtl/fp_accumulator.sv
// Sums TERMS single-precision products (sign/exp/frac from fpMul) into one IEEE-754 result.
// Latency: 3 clk per term (ALIGN, ADD, NORM); out_valid pulses in the DONE cycle after the last term.
// Backpressure: in_ready is high only in IDLE; upstream holds its product until accepted.
module fp_accumulator #(
    parameter int TERMS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [22:0] in_prod,
    output logic        out_valid,
    output logic [31:0] out_sum,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [7:0] TERMS_W = TERMS[7:0];

    state_t      state;
    logic [7:0]  count;

    // running sum; exponent 255 marks a sticky infinity
    logic        acc_sign;
    logic [7:0]  acc_exp;
    logic [22:0] acc_frac;

    // product captured on accept
    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_frac;

    // align-stage registers
    logic [23:0] big_man_r;
    logic [23:0] small_man_r;
    logic        big_sign_r;
    logic        small_sign_r;
    logic [7:0]  al_exp_r;
    logic        inf_r;
    logic        inf_sign_r;

    // add-stage registers
    logic [24:0] sum_r;
    logic        sum_sign_r;

    // align-stage combinational results
    logic [23:0] a_man;
    logic [23:0] b_man;
    logic [7:0]  diff;
    logic [23:0] big_man_n;
    logic [23:0] small_man_n;
    logic        big_sign_n;
    logic        small_sign_n;
    logic [7:0]  al_exp_n;
    logic        acc_is_inf;
    logic        op_is_inf;
    logic        inf_n;
    logic        inf_sign_n;

    // add-stage combinational results
    logic [24:0] sum_n;
    logic        sum_sign_n;

    // norm-stage combinational results
    logic [4:0]  lz;
    logic        lz_found;
    logic [22:0] norm_frac;
    logic [9:0]  exp_dec;
    logic [8:0]  exp_inc;
    logic [31:0] res;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE) || (count != 8'd0);

    // Align: pick the larger-exponent operand and shift the other right; zero exponent means zero
    always_comb begin
        a_man        = (acc_exp == 8'd0) ? 24'd0 : {1'b1, acc_frac};
        b_man        = (op_exp == 8'd0)  ? 24'd0 : {1'b1, op_frac};
        diff         = 8'd0;
        big_man_n    = a_man;
        small_man_n  = b_man;
        big_sign_n   = acc_sign;
        small_sign_n = op_sign;
        al_exp_n     = acc_exp;
        if (acc_exp >= op_exp) begin
            diff         = acc_exp - op_exp;
            big_man_n    = a_man;
            small_man_n  = (diff >= 8'd25) ? 24'd0 : (b_man >> diff);
            big_sign_n   = acc_sign;
            small_sign_n = op_sign;
            al_exp_n     = acc_exp;
        end else begin
            diff         = op_exp - acc_exp;
            big_man_n    = b_man;
            small_man_n  = (diff >= 8'd25) ? 24'd0 : (a_man >> diff);
            big_sign_n   = op_sign;
            small_sign_n = acc_sign;
            al_exp_n     = op_exp;
        end
        // infinities bypass the datapath; opposite infinities resolve to +inf
        acc_is_inf = (acc_exp == 8'hFF);
        op_is_inf  = (op_exp == 8'hFF);
        inf_n      = acc_is_inf || op_is_inf;
        if (acc_is_inf) begin
            inf_sign_n = (op_is_inf && (op_sign != acc_sign)) ? 1'b0 : acc_sign;
        end else begin
            inf_sign_n = op_sign;
        end
    end

    // Add: signed-magnitude add/sub, result takes the sign of the larger magnitude
    always_comb begin
        sum_n      = 25'd0;
        sum_sign_n = big_sign_r;
        if (big_sign_r == small_sign_r) begin
            sum_n      = {1'b0, big_man_r} + {1'b0, small_man_r};
            sum_sign_n = big_sign_r;
        end else if (big_man_r >= small_man_r) begin
            sum_n      = {1'b0, big_man_r} - {1'b0, small_man_r};
            sum_sign_n = big_sign_r;
        end else begin
            sum_n      = {1'b0, small_man_r} - {1'b0, big_man_r};
            sum_sign_n = small_sign_r;
        end
    end

    // Norm: carry shifts right once, otherwise leading-one detect and shift left; truncate
    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && sum_r[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
        norm_frac = sum_r[22:0] << lz;
        exp_dec   = {2'b00, al_exp_r} - {5'b00000, lz};
        exp_inc   = {1'b0, al_exp_r} + 9'd1;
        res       = 32'd0;
        if (inf_r) begin
            res = {inf_sign_r, 8'hFF, 23'd0};
        end else if (sum_r == 25'd0) begin
            res = 32'd0;
        end else if (sum_r[24]) begin
            if (exp_inc >= 9'd255) begin
                res = {sum_sign_r, 8'hFF, 23'd0};
            end else begin
                res = {sum_sign_r, exp_inc[7:0], sum_r[23:1]};
            end
        end else if (exp_dec[9] || (exp_dec == 10'd0)) begin
            res = 32'd0;
        end else begin
            res = {sum_sign_r, exp_dec[7:0], norm_frac};
        end
    end

    // Control FSM and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            count        <= 8'd0;
            acc_sign     <= 1'b0;
            acc_exp      <= 8'd0;
            acc_frac     <= 23'd0;
            op_sign      <= 1'b0;
            op_exp       <= 8'd0;
            op_frac      <= 23'd0;
            big_man_r    <= 24'd0;
            small_man_r  <= 24'd0;
            big_sign_r   <= 1'b0;
            small_sign_r <= 1'b0;
            al_exp_r     <= 8'd0;
            inf_r        <= 1'b0;
            inf_sign_r   <= 1'b0;
            sum_r        <= 25'd0;
            sum_sign_r   <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_sign <= in_sign;
                        op_exp  <= in_exponent;
                        op_frac <= in_prod;
                        state   <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    big_man_r    <= big_man_n;
                    small_man_r  <= small_man_n;
                    big_sign_r   <= big_sign_n;
                    small_sign_r <= small_sign_n;
                    al_exp_r     <= al_exp_n;
                    inf_r        <= inf_n;
                    inf_sign_r   <= inf_sign_n;
                    state        <= S_ADD;
                end
                S_ADD: begin
                    sum_r      <= sum_n;
                    sum_sign_r <= sum_sign_n;
                    state      <= S_NORM;
                end
                S_NORM: begin
                    acc_sign <= res[31];
                    acc_exp  <= res[30:23];
                    acc_frac <= res[22:0];
                    count    <= count + 8'd1;
                    if ((count + 8'd1) == TERMS_W) begin
                        out_sum   <= res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b0;
                    acc_sign  <= 1'b0;
                    acc_exp   <= 8'd0;
                    acc_frac  <= 23'd0;
                    count     <= 8'd0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator with a 3-term window.
// Stimulus pushes expected sums and accept times; a negedge monitor pops on out_valid.
// Directed cases cover the documented examples, then randomized windows with idle gaps.
module tb_fp_accumulator;

    localparam int TERMS = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [22:0] in_prod;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        busy;

    fp_accumulator #(.TERMS(TERMS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exponent (in_exponent),
        .in_prod     (in_prod),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];

    logic [31:0] model_acc = 32'd0;
    int          model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value = +/- mantissa * 2^exp using plain integers, truncating alignment.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic s,
                                            input logic [7:0] e, input logic [22:0] f);
        longint ma, mb, v, mag;
        int     ea, eb, ex, d;
        logic   sg;
        ea = int'(a[30:23]);
        eb = int'(e);
        if (ea == 255) return (eb == 255 && s != a[31]) ? 32'h7F800000 : a;
        if (eb == 255) return {s, 8'hFF, 23'd0};
        ma = (ea == 0) ? 0 : (longint'(8388608) + longint'(a[22:0]));
        mb = (eb == 0) ? 0 : (longint'(8388608) + longint'(f));
        if (ea >= eb) begin
            d  = ea - eb;
            mb = (d >= 25) ? 0 : (mb >> d);
            ex = ea;
        end else begin
            d  = eb - ea;
            ma = (d >= 25) ? 0 : (ma >> d);
            ex = eb;
        end
        v = (a[31] ? -ma : ma) + (s ? -mb : mb);
        if (v == 0) return 32'd0;
        sg  = (v < 0);
        mag = sg ? -v : v;
        while (mag >= 64'd16777216) begin
            mag = mag >> 1;
            ex++;
        end
        while (mag < 64'd8388608) begin
            mag = mag << 1;
            ex--;
        end
        if (ex >= 255) return {sg, 8'hFF, 23'd0};
        if (ex <= 0) return 32'd0;
        return {sg, 8'(ex), 23'(mag)};
    endfunction

    task automatic model_accept(input logic s, input logic [7:0] e, input logic [22:0] f,
                                input int acc_cyc);
        model_acc = ref_add(model_acc, s, e, f);
        model_cnt++;
        if (model_cnt == TERMS) begin
            exp_q.push_back(model_acc);
            cyc_q.push_back(acc_cyc);
            model_acc = 32'd0;
            model_cnt = 0;
        end
    endtask

    // Present one product and wait (bounded) until it is accepted.
    task automatic send(input logic s, input logic [7:0] e, input logic [22:0] f);
        int t;
        @(negedge clk);
        in_valid    = 1'b1;
        in_sign     = s;
        in_exponent = e;
        in_prod     = f;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 clk");
        end else begin
            @(posedge clk);
            #1;
            model_accept(s, e, f, cyc);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Directed windows replace the model's pushed value with the documented constant.
    task automatic expect_const(input logic [31:0] k);
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = k;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    // Monitor: out_valid appears in the 4th cycle after the last accept (ALIGN, ADD, NORM, DONE).
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: out_sum=%h with no result pending", out_sum);
            end else begin
                logic [31:0] e;
                int          c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("out_sum", out_sum, e);
                check("latency", 32'(cyc - c), 32'd3);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = 8'd0;
        in_prod     = 23'd0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", out_sum, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 15 + 24 - 25 = 14
        send(1'b0, 8'h82, 23'h700000);
        send(1'b0, 8'h83, 23'h400000);
        send(1'b1, 8'h83, 23'h480000);
        expect_const(32'h41600000);
        idle(2);
        wait_idle();

        // exact cancellation, then a zero operand
        send(1'b0, 8'h88, 23'h1C4000);
        send(1'b1, 8'h88, 23'h1C4000);
        send(1'b0, 8'h00, 23'h123456);
        expect_const(32'h00000000);
        idle(1);
        wait_idle();

        // tiny operand 27 binades below is discarded
        send(1'b0, 8'h94, 23'h41E1F0);
        send(1'b0, 8'h79, 23'h1C6A7F);
        send(1'b0, 8'h00, 23'h000000);
        expect_const(32'h4A41E1F0);
        idle(1);
        wait_idle();

        // overflow to +inf, which stays sticky against a later finite term
        send(1'b0, 8'hFE, 23'h7FFFFF);
        send(1'b0, 8'hFE, 23'h7FFFFF);
        send(1'b1, 8'h7F, 23'h000000);
        expect_const(32'h7F800000);
        idle(1);
        wait_idle();

        // +inf + -inf gives +inf
        send(1'b0, 8'hFF, 23'h000001);
        send(1'b1, 8'hFF, 23'h000000);
        send(1'b1, 8'h80, 23'h000000);
        expect_const(32'h7F800000);
        idle(1);
        wait_idle();

        // partial cancellation below the smallest normal flushes to +0
        send(1'b0, 8'h01, 23'h400000);
        send(1'b1, 8'h01, 23'h3FFFFF);
        send(1'b0, 8'h00, 23'h000000);
        expect_const(32'h00000000);
        idle(1);
        wait_idle();

        // in_valid held high with 1.0: in_ready must follow 1,0,0,0; sum is 3.0
        @(negedge clk);
        in_valid    = 1'b1;
        in_sign     = 1'b0;
        in_exponent = 8'h7F;
        in_prod     = 23'd0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            check("in_ready_pattern", 32'(in_ready), (i % 4 == 0) ? 32'd1 : 32'd0);
            if (in_ready) model_accept(1'b0, 8'h7F, 23'd0, cyc + 1);
        end
        expect_const(32'h40400000);
        in_valid = 1'b0;
        wait_idle();

        // reset during ADD of the second term, then a clean window
        send(1'b0, 8'h85, 23'h2AAAAA);
        send(1'b0, 8'h86, 23'h155555);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_acc = 32'd0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 8'h80, 23'h000000);
        send(1'b0, 8'h7F, 23'h000000);
        send(1'b0, 8'h7E, 23'h000000);
        expect_const(32'h40600000);
        idle(1);
        wait_idle();

        // randomized windows with idle gaps and forced cancellations
        for (int w = 0; w < 40; w++) begin
            logic [7:0]  pe;
            logic [22:0] pf;
            logic        ps;
            for (int k = 0; k < TERMS; k++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                ps  = 1'($urandom_range(0, 1));
                if (sel == 0) begin
                    pe = 8'd0;
                    pf = 23'($urandom);
                end else if (sel == 1 && k > 0) begin
                    ps = ~ps;
                end else begin
                    pe = 8'($urandom_range(110, 140));
                    pf = 23'($urandom);
                end
                send(ps, pe, pf);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 3)));
            end
        end
        idle(1);
        wait_idle();

        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
